// File: rtl/eu_sequencer_if.sv
// Instruction-fetch and execution-unit bus between eu_sequencer (master)
// and the instruction memory / execution unit (slave).
interface eu_sequencer_if #(parameter int PC_W = 8);
  logic [PC_W-1:0] pc;
  logic            instr_req;
  logic            instr_valid;
  logic [15:0]     instr;
  logic [4:0]      fl;
  logic [3:0]      opcode;
  logic [3:0]      a;
  logic [3:0]      b;
  logic [3:0]      c;
  logic [3:0]      address;
  logic            read_enable;
  logic            write_enable;
  logic [1:0]      en;
  logic            busy;
  logic            halted;
  logic            illegal;

  modport master (
    output pc, instr_req, opcode, a, b, c, address,
           read_enable, write_enable, en, busy, halted, illegal,
    input  instr_valid, instr, fl
  );

  modport slave (
    input  pc, instr_req, opcode, a, b, c, address,
           read_enable, write_enable, en, busy, halted, illegal,
    output instr_valid, instr, fl
  );
endinterface

// File: rtl/eu_sequencer.sv
// Fetch/decode sequencer feeding the execution unit; resolves BZ and HALT
// locally and issues ALU / LOAD / STORE one instruction at a time.
module eu_sequencer #(
  parameter int PC_W        = 8,
  parameter int EXEC_CYCLES = 2,
  parameter int NUM_REGS    = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  eu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALTED
  } state_t;

  // Every visible output lives in this one registered record.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            instr_req;
    logic [3:0]      opcode;
    logic [3:0]      a;
    logic [3:0]      b;
    logic [3:0]      c;
    logic [3:0]      address;
    logic            re;
    logic            we;
    logic [1:0]      en;
    logic            busy;
    logic            halted;
    logic            illegal;
  } out_t;

  localparam logic [3:0] MAX_REG   = 4'(NUM_REGS - 1);
  localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES);
  localparam logic [1:0] EN_ALU    = 2'b00;
  localparam logic [1:0] EN_MEM    = 2'b01;
  localparam logic [1:0] EN_IDLE   = 2'b11;

  localparam out_t OUT_RST = '{
    pc: '0, instr_req: 1'b0, opcode: 4'h0, a: 4'h0, b: 4'h0, c: 4'h0,
    address: 4'h0, re: 1'b0, we: 1'b0, en: EN_IDLE, busy: 1'b0,
    halted: 1'b0, illegal: 1'b0
  };

  state_t      state_q, state_d;
  out_t        out_q, out_d;
  logic [15:0] instr_q, instr_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [3:0]      op, rc, ra, rb;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] br_tgt;

  assign op     = instr_q[15:12];
  assign rc     = instr_q[11:8];
  assign ra     = instr_q[7:4];
  assign rb     = instr_q[3:0];
  assign pc_inc = out_q.pc + PC_W'(1);
  assign br_tgt = PC_W'(instr_q[7:0]);

  logic unused_fl;
  assign unused_fl = ^bus.fl[4:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      out_q   <= OUT_RST;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d         = S_FETCH;
          out_d.instr_req = 1'b1;
        end
      end
      S_FETCH: begin
        if (bus.instr_valid) begin
          instr_d         = bus.instr;
          out_d.instr_req = 1'b0;
          state_d         = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op <= 4'hB) begin
          if (ra > MAX_REG || rb > MAX_REG || rc > MAX_REG) begin
            out_d.illegal = 1'b1;
            out_d.halted  = 1'b1;
            state_d       = S_HALTED;
          end else begin
            out_d.opcode = op;
            out_d.a      = ra;
            out_d.b      = rb;
            out_d.c      = rc;
            out_d.en     = EN_ALU;
            cnt_d        = 4'd1;
            state_d      = S_EXEC;
          end
        end else begin
          case (op)
            4'hC: begin
              out_d.pc        = bus.fl[0] ? br_tgt : pc_inc;
              out_d.instr_req = 1'b1;
              state_d         = S_FETCH;
            end
            4'hD: begin
              out_d.halted = 1'b1;
              state_d      = S_HALTED;
            end
            default: begin
              // LOAD (0xE) and STORE (0xF) share decode; only the strobe differs.
              if (rb > MAX_REG) begin
                out_d.illegal = 1'b1;
                out_d.halted  = 1'b1;
                state_d       = S_HALTED;
              end else begin
                out_d.address = rb;
                out_d.re      = (op == 4'hE);
                out_d.we      = (op == 4'hF);
                out_d.en      = EN_MEM;
                state_d       = S_MEM;
              end
            end
          endcase
        end
      end
      S_EXEC: begin
        if (cnt_q >= EXEC_LAST) begin
          out_d.pc        = pc_inc;
          out_d.en        = EN_IDLE;
          out_d.instr_req = 1'b1;
          state_d         = S_FETCH;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_MEM: begin
        out_d.re        = 1'b0;
        out_d.we        = 1'b0;
        out_d.en        = EN_IDLE;
        out_d.pc        = pc_inc;
        out_d.instr_req = 1'b1;
        state_d         = S_FETCH;
      end
      S_HALTED: begin
        out_d.en        = EN_IDLE;
        out_d.instr_req = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        out_d   = OUT_RST;
      end
    endcase
    // busy is registered from the state being entered, so it tracks state exactly.
    out_d.busy = !(state_d inside {S_IDLE, S_HALTED});
  end

  assign bus.pc           = out_q.pc;
  assign bus.instr_req    = out_q.instr_req;
  assign bus.opcode       = out_q.opcode;
  assign bus.a            = out_q.a;
  assign bus.b            = out_q.b;
  assign bus.c            = out_q.c;
  assign bus.address      = out_q.address;
  assign bus.read_enable  = out_q.re;
  assign bus.write_enable = out_q.we;
  assign bus.en           = out_q.en;
  assign bus.busy         = out_q.busy;
  assign bus.halted       = out_q.halted;
  assign bus.illegal      = out_q.illegal;

endmodule

// File: tb/tb_eu_sequencer.sv
// Self-checking bench for eu_sequencer: vector table, corner sequences and a
// random program run against an instruction-level reference model.
module tb_eu_sequencer;
  localparam int PC_W = 8, EXEC_CYCLES = 2, NUM_REGS = 6;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  eu_sequencer_if #(.PC_W(PC_W)) bus ();

  eu_sequencer #(.PC_W(PC_W), .EXEC_CYCLES(EXEC_CYCLES), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_bad = 0;
  logic [15:0] imem [256];
  int          resp_lat = 0;
  bit          saw_en00 = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Instruction memory: answers a request after resp_lat idle cycles.
  initial begin
    int waited = 0;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0;
    forever begin
      @(posedge clk); #2;
      if (bus.instr_req) begin
        if (waited >= resp_lat) begin
          bus.instr_valid = 1'b1;
          bus.instr       = imem[bus.pc];
        end else begin
          bus.instr_valid = 1'b0;
          waited++;
        end
      end else begin
        bus.instr_valid = 1'b0;
        waited = 0;
      end
    end
  end

  // Strobe invariants hold every cycle out of reset.
  initial forever begin
    @(posedge clk); #1;
    if (rst_n) begin
      chk("rw_exclusive", bus.read_enable & bus.write_enable, 0);
      chk("strobe_in_alu", (bus.read_enable | bus.write_enable) && bus.en == 2'b00, 0);
      if (bus.en == 2'b00) saw_en00 = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    chk("reset_outputs",
        {bus.pc, bus.instr_req, bus.opcode, bus.a, bus.b, bus.c, bus.address,
         bus.read_enable, bus.write_enable, bus.en, bus.busy, bus.halted, bus.illegal},
        {8'h00, 1'b0, 20'h0, 2'b00, 2'b11, 3'b000});
    step(); step();
    rst_n = 1'b1;
    saw_en00 = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // From a sample with instr_req=1: wait for the fetch to be taken, then
  // count samples until the next fetch request or halt.
  task automatic next_instr(input string name, output int t);
    int k = 0;
    while (bus.instr_req && k < 50) begin step(); k++; end
    t = 0;
    while (!bus.instr_req && !bus.halted && t < 50) begin step(); t++; end
    if (k >= 50 || t >= 50) chk({name, "_timeout"}, 1, 0);
  endtask

  // Instruction-level reference: what one instruction does to pc and the bus.
  task automatic model(input logic [7:0] pc, input logic [15:0] ins, input logic z,
                       output int lat, output int n00, output int nre, output int nwe,
                       output logic [7:0] npc, output bit h, output bit ill);
    int op, rc, ra, rb;
    op = int'(ins[15:12]); rc = int'(ins[11:8]); ra = int'(ins[7:4]); rb = int'(ins[3:0]);
    npc = pc + 8'd1; h = 0; ill = 0; n00 = 0; nre = 0; nwe = 0; lat = 1;
    if (op <= 11) begin
      if (ra >= NUM_REGS || rb >= NUM_REGS || rc >= NUM_REGS) begin
        ill = 1; h = 1; npc = pc;
      end else begin
        lat = 1 + EXEC_CYCLES; n00 = EXEC_CYCLES;
      end
    end else if (op == 12) begin
      if (z) npc = ins[7:0];
    end else if (op == 13) begin
      h = 1; npc = pc;
    end else if (rb >= NUM_REGS) begin
      ill = 1; h = 1; npc = pc;
    end else begin
      lat = 2; nre = (op == 14); nwe = (op == 15);
    end
  endtask

  function automatic logic [15:0] rand_instr();
    int r;
    logic [3:0] op;
    r = $urandom_range(0, 99);
    if (r < 96) begin
      if (r < 50)      op = 4'($urandom_range(0, 11));
      else if (r < 70) op = 4'hC;
      else if (r < 94) op = (r % 2 == 0) ? 4'hE : 4'hF;
      else             op = 4'hD;
      if (op == 4'hC) return {op, 4'($urandom), 8'($urandom)};
      return {op, 4'($urandom_range(0, NUM_REGS-1)), 4'($urandom_range(0, NUM_REGS-1)),
              4'($urandom_range(0, NUM_REGS-1))};
    end
    return 16'($urandom);
  endfunction

  typedef struct {
    logic [15:0] ins;
    logic        fl0;
    int          lat;
    logic [1:0]  en1;
    logic        re1, we1;
    logic [3:0]  addr1;
    logic [7:0]  pc_n;
    logic        hlt, ill;
  } vec_t;

  vec_t tv [13];

  initial begin
    int t;
    tv = '{
      '{16'h1201, 1'b0, 3, 2'b00, 1'b0, 1'b0, 4'h0, 8'h01, 1'b0, 1'b0},
      '{16'hB555, 1'b1, 3, 2'b00, 1'b0, 1'b0, 4'h0, 8'h01, 1'b0, 1'b0},
      '{16'hE003, 1'b0, 2, 2'b01, 1'b1, 1'b0, 4'h3, 8'h01, 1'b0, 1'b0},
      '{16'hF005, 1'b1, 2, 2'b01, 1'b0, 1'b1, 4'h5, 8'h01, 1'b0, 1'b0},
      '{16'hC040, 1'b1, 1, 2'b11, 1'b0, 1'b0, 4'h0, 8'h40, 1'b0, 1'b0},
      '{16'hC040, 1'b0, 1, 2'b11, 1'b0, 1'b0, 4'h0, 8'h01, 1'b0, 1'b0},
      '{16'hC0FF, 1'b1, 1, 2'b11, 1'b0, 1'b0, 4'h0, 8'hFF, 1'b0, 1'b0},
      '{16'hD000, 1'b1, 1, 2'b11, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0},
      '{16'h2070, 1'b0, 1, 2'b11, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1},
      '{16'h1600, 1'b0, 1, 2'b11, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1},
      '{16'h1006, 1'b0, 1, 2'b11, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1},
      '{16'hE007, 1'b0, 1, 2'b11, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1},
      '{16'hF00F, 1'b1, 1, 2'b11, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1}
    };
    bus.fl = 5'h0;
    for (int i = 0; i < 256; i++) imem[i] = 16'hD000;
    repeat (2) @(posedge clk);
    #1;

    // Vector table: each record is a single instruction run from pc=0.
    foreach (tv[i]) begin
      do_reset();
      imem[0]  = tv[i].ins;
      bus.fl   = {4'h0, tv[i].fl0};
      resp_lat = 0;
      kick();
      chk("start_req", {bus.instr_req, bus.busy}, 2'b11);
      step();
      chk("decode_req", bus.instr_req, 0);
      step();
      chk("post_en", bus.en, tv[i].en1);
      chk("post_strobes", {bus.read_enable, bus.write_enable}, {tv[i].re1, tv[i].we1});
      chk("post_addr", bus.address, tv[i].addr1);
      chk("post_alu", {bus.opcode, bus.c, bus.a, bus.b},
          (tv[i].en1 == 2'b00) ? tv[i].ins : 16'h0);
      t = 1;
      while (!bus.instr_req && !bus.halted && t < 40) begin step(); t++; end
      chk("latency", t, tv[i].lat);
      chk("next_pc", bus.pc, tv[i].pc_n);
      chk("halt_ill", {bus.halted, bus.illegal}, {tv[i].hlt, tv[i].ill});
      chk("en00_seen", saw_en00, tv[i].en1 == 2'b00);
    end

    // Fetch stall: request held, outputs frozen while memory is silent.
    do_reset();
    imem[0] = 16'h1201; resp_lat = 5;
    kick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_hold", {bus.instr_req, bus.pc, bus.en, bus.busy}, {1'b1, 8'h00, 2'b11, 1'b1});
      step();
    end
    next_instr("stall", t);
    chk("stall_lat", t, 1 + EXEC_CYCLES);
    chk("stall_pc", bus.pc, 8'h01);

    // pc wrap: branch to 0xFF, ALU there lands on 0x00.
    do_reset();
    resp_lat = 0; bus.fl = 5'h01;
    imem[0] = 16'hC0FF; imem[255] = 16'h1201;
    kick();
    next_instr("wrap_bz", t);
    chk("wrap_bz_pc", bus.pc, 8'hFF);
    next_instr("wrap_alu", t);
    chk("wrap_pc", bus.pc, 8'h00);
    chk("wrap_lat", t, 1 + EXEC_CYCLES);
    imem[255] = 16'hD000;

    // Reset mid-EXEC, then HALT ignores start.
    do_reset();
    imem[0] = 16'h1201;
    kick(); step(); step();
    chk("mid_exec_en", bus.en, 2'b00);
    do_reset();
    imem[0] = 16'hD000;
    kick();
    next_instr("halt", t);
    chk("halt_flag", {bus.halted, bus.busy, bus.en}, {1'b1, 1'b0, 2'b11});
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    chk("halt_sticky", {bus.halted, bus.instr_req, bus.busy, bus.pc}, {1'b1, 1'b0, 1'b0, 8'h00});

    // Random programs against the reference model.
    for (int run = 0; run < 6; run++) begin
      bit inflight, done, prev_req, eh, ei;
      int tt, cyc, ninstr, el, e00, ere, ewe, c00, cre, cwe;
      logic [7:0] epc;
      do_reset();
      for (int i = 0; i < 256; i++) imem[i] = rand_instr();
      resp_lat = $urandom_range(0, 3);
      bus.fl = 5'($urandom);
      kick();
      prev_req = bus.instr_req;
      inflight = 0; done = 0; cyc = 0; ninstr = 0; tt = 0;
      el = 0; e00 = 0; ere = 0; ewe = 0; c00 = 0; cre = 0; cwe = 0;
      epc = 8'h00; eh = 0; ei = 0;
      while (!done && cyc < 2000) begin
        step(); cyc++;
        if (inflight) begin
          tt++;
          if (bus.en == 2'b00) c00++;
          if (bus.read_enable) cre++;
          if (bus.write_enable) cwe++;
          if (bus.instr_req || bus.halted || tt > 30) begin
            chk("rnd_latency", tt, el);
            chk("rnd_pc", bus.pc, epc);
            chk("rnd_en00_cycles", c00, e00);
            chk("rnd_strobes", {cre[7:0], cwe[7:0]}, {ere[7:0], ewe[7:0]});
            chk("rnd_halt_ill", {bus.halted, bus.illegal}, {eh, ei});
            inflight = 0; ninstr++;
            if (bus.halted || tt > 30 || ninstr >= 60) done = 1;
          end
        end
        bus.fl = 5'($urandom);
        if (prev_req && !bus.instr_req && !bus.halted) begin
          model(bus.pc, imem[bus.pc], bus.fl[0], el, e00, ere, ewe, epc, eh, ei);
          inflight = 1; tt = 0; c00 = 0; cre = 0; cwe = 0;
        end
        prev_req = bus.instr_req;
      end
      if (!done) chk("rnd_timeout", 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
